// File: rtl/sram_req_adapter.sv
// Valid/ready request front end for the sram_top macro: one SRAM access in flight, in-order
// responses through a small FIFO. Define SRAM_ADAPTER_ACCESS_CHECK_EN to flag bad addresses.
module sram_req_adapter #(
  parameter int unsigned RSP_DEPTH = 3,
  parameter int unsigned SRAM_AW   = 12
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [31:0]        req_addr_i,
  input  logic               req_we_i,
  input  logic [3:0]         req_be_i,
  input  logic [31:0]        req_wdata_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [31:0]        rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               csb_o,
  output logic               we_o,
  output logic [SRAM_AW-1:0] addr_o,
  output logic [31:0]        wdata_o,
  output logic [3:0]         wmask_o,
  input  logic [31:0]        rdata_i
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RSP_DEPTH - 1);
  localparam logic [OccW-1:0] DepthOcc = OccW'(RSP_DEPTH);

  logic            infl_v_q, infl_v_d;
  logic            infl_we_q, infl_we_d;
  logic            infl_err_q, infl_err_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     rdata_mem_q [RSP_DEPTH];
  logic            err_mem_q   [RSP_DEPTH];

  logic            accept;
  logic            req_err;
  logic            access;
  logic            push;
  logic            pop;
  logic [31:0]     push_rdata;
  logic [OccW-1:0] occupancy;

  // Buffered responses plus the one in flight must fit, so a push can never overflow.
  assign occupancy   = {1'b0, count_q} + {{CntW{1'b0}}, infl_v_q};
  assign req_ready_o = !rst_i && (occupancy < DepthOcc);
  assign accept      = req_valid_i && req_ready_o;

`ifdef SRAM_ADAPTER_ACCESS_CHECK_EN
  assign req_err = (req_addr_i[1:0] != 2'b00) || (|req_addr_i[31:SRAM_AW+2]);
`else
  assign req_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[31:SRAM_AW+2], req_addr_i[1:0]};
`endif

  assign access = accept && !req_err;

  always_comb begin
    csb_o   = 1'b1;
    we_o    = 1'b1;
    addr_o  = '0;
    wdata_o = '0;
    wmask_o = 4'b0000;
    if (access) begin
      csb_o   = 1'b0;
      we_o    = !req_we_i;
      addr_o  = req_addr_i[SRAM_AW+1:2];
      wdata_o = req_wdata_i;
      wmask_o = req_we_i ? req_be_i : 4'b0000;
    end
  end

  always_comb begin
    infl_v_d   = accept;
    infl_we_d  = accept ? req_we_i : 1'b0;
    infl_err_d = accept ? req_err : 1'b0;
  end

  assign push       = infl_v_q;
  assign push_rdata = (!infl_we_q && !infl_err_q) ? rdata_i : 32'h0;
  assign pop        = rsp_valid_o && rsp_ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      infl_v_q   <= 1'b0;
      infl_we_q  <= 1'b0;
      infl_err_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rdata_mem_q[i] <= 32'h0;
        err_mem_q[i]   <= 1'b0;
      end
    end else begin
      infl_v_q   <= infl_v_d;
      infl_we_q  <= infl_we_d;
      infl_err_q <= infl_err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      if (push) begin
        rdata_mem_q[wptr_q] <= push_rdata;
        err_mem_q[wptr_q]   <= infl_err_q;
      end
    end
  end

  assign rsp_valid_o = !rst_i && (count_q != '0);
  assign rsp_rdata_o = rsp_valid_o ? rdata_mem_q[rptr_q] : 32'h0;
`ifdef SRAM_ADAPTER_ACCESS_CHECK_EN
  assign rsp_err_o   = rsp_valid_o ? err_mem_q[rptr_q] : 1'b0;
`else
  assign rsp_err_o   = 1'b0;
  logic unused_err_mem;
  assign unused_err_mem = err_mem_q[rptr_q];
`endif

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter: pin/response vector table plus back-pressure, streaming,
// latency and mid-operation reset sequences, with a behavioural SRAM attached.
module tb_sram_req_adapter;

  localparam int unsigned Depth = 3;
  localparam int unsigned Aw    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [31:0]   req_addr, req_wdata;
  logic [3:0]    req_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          csb, we_n;
  logic [Aw-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic [3:0]    sram_wmask;

  sram_req_adapter #(.RSP_DEPTH(Depth), .SRAM_AW(Aw)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_be_i(req_be), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .csb_o(csb), .we_o(we_n), .addr_o(sram_addr), .wdata_o(sram_wdata),
    .wmask_o(sram_wmask), .rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          exp_csb;
    logic          exp_we;
    logic [Aw-1:0] exp_addr;
    logic [3:0]    exp_wmask;
    logic [31:0]   exp_wdata;
    logic [31:0]   exp_rdata;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   n_acc  = 0;
  int   n_rsp  = 0;
  int   acc_cyc = 0;
  int   last_rsp_cyc = 0;
  exp_t exp_q[$];

  // Behavioural single-port SRAM: registered read, masked write.
  logic [31:0] mem [4096];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (!csb) begin
      if (!we_n) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (req_valid && req_ready) n_acc++;
    if (rsp_valid && rsp_ready) begin
      exp_t e;
      n_rsp++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  always @(posedge clk) begin
    if (exp_q.size() > Depth) begin
      n_miss++;
      $display("FAIL overflow: got %0d outstanding, expected at most %0d", exp_q.size(), Depth);
    end
  end

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic csb_e, input logic we_e,
                              input logic [Aw-1:0] a_e, input logic [3:0] wm_e,
                              input logic [31:0] wd_e, input logic [31:0] rd_e,
                              input logic err_e);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
    v.exp_csb = csb_e; v.exp_we = we_e; v.exp_addr = a_e; v.exp_wmask = wm_e;
    v.exp_wdata = wd_e; v.exp_rdata = rd_e; v.exp_err = err_e;
    return v;
  endfunction

  function automatic vec_t rd(input logic [31:0] addr, input logic [31:0] data);
    return mk(1'b0, addr, 4'h0, 32'h0, 1'b0, 1'b1, addr[Aw+1:2], 4'h0, 32'h0, data, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, wait (bounded) for acceptance, check the SRAM pins in the accept cycle.
  task automatic send(input vec_t v);
    bit   done;
    exp_t e;
    done = 1'b0;
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_be = v.be; req_wdata = v.wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        chk("sram_pins", 32'({csb, we_n, sram_addr, sram_wmask}),
            32'({v.exp_csb, v.exp_we, v.exp_addr, v.exp_wmask}));
        chk("sram_wdata", sram_wdata, v.exp_wdata);
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        exp_q.push_back(e);
        acc_cyc = cyc;
        done = 1'b1;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
  endtask

  vec_t        tbl [10];
  logic [31:0] s_addr [4];
  logic [31:0] s_data [4];
  int          c0, first_acc, rsp0;

  initial begin
    tbl[0] = mk(1, 32'h10, 4'hF, 32'hDEAD_BEEF, 0, 0, 12'h004, 4'hF, 32'hDEAD_BEEF, 32'h0, 0);
    tbl[1] = rd(32'h10, 32'hDEAD_BEEF);
    tbl[2] = mk(1, 32'h0, 4'hF, 32'h1122_3344, 0, 0, 12'h000, 4'hF, 32'h1122_3344, 32'h0, 0);
    tbl[3] = mk(1, 32'h0, 4'h2, 32'h0000_AA00, 0, 0, 12'h000, 4'h2, 32'h0000_AA00, 32'h0, 0);
    tbl[4] = rd(32'h0, 32'h1122_AA44);
    tbl[5] = mk(1, 32'h3FFC, 4'h1, 32'h1234_56A5, 0, 0, 12'hFFF, 4'h1, 32'h1234_56A5, 32'h0, 0);
    tbl[6] = rd(32'h3FFC, 32'h0000_00A5);
`ifdef SRAM_ADAPTER_ACCESS_CHECK_EN
    tbl[7] = mk(0, 32'h4002, 4'h0, 32'h0, 1, 1, 12'h000, 4'h0, 32'h0, 32'h0, 1);
`else
    tbl[7] = mk(0, 32'h4002, 4'h0, 32'h0, 0, 1, 12'h000, 4'h0, 32'h0, 32'h1122_AA44, 0);
`endif
    tbl[8] = mk(1, 32'h8, 4'hC, 32'hCAFE_1234, 0, 0, 12'h002, 4'hC, 32'hCAFE_1234, 32'h0, 0);
    tbl[9] = rd(32'h8, 32'hCAFE_0000);
    s_addr[0] = 32'h10;   s_data[0] = 32'hDEAD_BEEF;
    s_addr[1] = 32'h0;    s_data[1] = 32'h1122_AA44;
    s_addr[2] = 32'h3FFC; s_data[2] = 32'h0000_00A5;
    s_addr[3] = 32'h8;    s_data[3] = 32'hCAFE_0000;

    // Reset with a write request held: nothing may reach the SRAM.
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_be = 4'hF; req_wdata = 32'hFFFF_FFFF;
    tick(); tick();
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_pins", 32'({csb, we_n, sram_addr, sram_wmask}), 32'({1'b1, 1'b1, 12'h0, 4'h0}));
    chk("reset_wdata", sram_wdata, 32'h0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    tick();

    for (int i = 0; i < 10; i++) send(tbl[i]);
    drain();

    // Latency: idle read responds two cycles after acceptance.
    send(rd(32'h10, 32'hDEAD_BEEF));
    @(negedge clk);
    chk("latency_t1_valid", 32'(rsp_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("latency_t2_valid", 32'(rsp_valid), 32'd1);
    tick();
    drain();

    // Back-pressure: exactly Depth accepts, then ready reopens one cycle after a pop.
    rsp_ready = 1'b0;
    n_acc = 0;
    rsp0  = n_rsp;
    for (int i = 0; i < 3; i++) send(rd(s_addr[i], s_data[i]));
    req_valid = 1'b1; req_we = 1'b0; req_addr = s_addr[3]; req_be = 4'h0; req_wdata = 32'h0;
    repeat (6) tick();
    @(negedge clk);
    chk("bp_accepts", 32'(n_acc), 32'd3);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    tick();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_pop", 32'(req_ready), 32'd0);
    c0 = cyc;
    tick();
    send(rd(s_addr[3], s_data[3]));
    chk("bp_reopen_cycle", 32'(acc_cyc - c0), 32'd1);
    send(rd(s_addr[0], s_data[0]));
    drain();
    chk("bp_rsp_count", 32'(n_rsp - rsp0), 32'd5);

    // Streaming: 16 back-to-back reads, one accept and one response per cycle.
    rsp0 = n_rsp;
    send(rd(s_addr[0], s_data[0]));
    first_acc = acc_cyc;
    for (int i = 1; i < 16; i++) send(rd(s_addr[i % 4], s_data[i % 4]));
    chk("stream_accept_span", 32'(acc_cyc - first_acc), 32'd15);
    drain();
    chk("stream_rsp_count", 32'(n_rsp - rsp0), 32'd16);
    chk("stream_rsp_span", 32'(last_rsp_cyc - first_acc), 32'd17);

    // Reset with two responses buffered and one in flight: all are dropped.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rd(s_addr[i], s_data[i]));
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = s_addr[3];
    exp_q.delete();
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_csb", 32'(csb), 32'd1);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("postrst_ready", 32'(req_ready), 32'd1);
    chk("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rsp_ready = 1'b1;
    repeat (6) tick();
    send(rd(32'h8, 32'hCAFE_0000));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
